// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, 4-bit IR, BYPASS and IDCODE data
// registers, with TDO and IR_OUT updated on the falling edge of TCK.
module tap_ctrl (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       BSR_TDO,
  output logic       TDO,
  output logic       TDO_EN,
  output logic       CAPTURE_DR,
  output logic       SHIFT_DR,
  output logic       UPDATE_DR,
  output logic [3:0] IR_OUT,
  output logic       SEL_BSR,
  output logic       MODE,
  output logic [3:0] TAP_STATE
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [3:0]  INSTR_EXTEST = 4'b0000;
  localparam logic [3:0]  INSTR_SAMPLE = 4'b0001;
  localparam logic [3:0]  INSTR_IDCODE = 4'b0010;
  localparam logic [31:0] IDCODE_VAL   = 32'h1876_5001;

  tap_state_e  state_q, state_d;
  logic [3:0]  ir_sr_q, ir_sr_d;
  logic        bypass_q, bypass_d;
  logic [31:0] idcode_q, idcode_d;
  logic [3:0]  ir_q, ir_d;
  logic        tdo_q, tdo_d;
  logic        tdo_en_q, tdo_en_d;
  logic        dr_tdo;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = TMS ? TLR    : RTI;
      RTI:      state_d = TMS ? SEL_DR : RTI;
      SEL_DR:   state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:    state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:   state_d = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:   state_d = TMS ? SEL_DR : RTI;
      SEL_IR:   state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:   state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:    state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:   state_d = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:   state_d = TMS ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Shift registers only move in Capture/Shift; Pause and Exit states hold them.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    bypass_d = bypass_q;
    idcode_d = idcode_q;
    case (state_q)
      CAP_IR: ir_sr_d = 4'b0001;
      SH_IR:  ir_sr_d = {TDI, ir_sr_q[3:1]};
      CAP_DR: begin
        bypass_d = 1'b0;
        idcode_d = IDCODE_VAL;
      end
      SH_DR: begin
        bypass_d = TDI;
        idcode_d = {TDI, idcode_q[31:1]};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q  <= TLR;
      ir_sr_q  <= 4'b0001;
      bypass_q <= 1'b0;
      idcode_q <= IDCODE_VAL;
    end else begin
      state_q  <= state_d;
      ir_sr_q  <= ir_sr_d;
      bypass_q <= bypass_d;
      idcode_q <= idcode_d;
    end
  end

  assign SEL_BSR = (ir_q == INSTR_EXTEST) || (ir_q == INSTR_SAMPLE);
  assign MODE    = (ir_q == INSTR_EXTEST);
  // Unlisted codes fall through to the bypass bit, matching BYPASS behaviour.
  assign dr_tdo  = SEL_BSR ? BSR_TDO :
                   (ir_q == INSTR_IDCODE) ? idcode_q[0] : bypass_q;

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    ir_d     = ir_q;
    case (state_q)
      SH_DR: begin
        tdo_d    = dr_tdo;
        tdo_en_d = 1'b1;
      end
      SH_IR: begin
        tdo_d    = ir_sr_q[0];
        tdo_en_d = 1'b1;
      end
      UPD_IR:  ir_d = ir_sr_q;
      TLR:     ir_d = INSTR_IDCODE;
      default: ;
    endcase
  end

  // NOTE: TDO and IR_OUT change on the falling edge so downstream logic sees them stable at the rise.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
      ir_q     <= INSTR_IDCODE;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
      ir_q     <= ir_d;
    end
  end

  assign TDO        = tdo_q;
  assign TDO_EN     = tdo_en_q;
  assign IR_OUT     = ir_q;
  assign TAP_STATE  = state_q;
  assign CAPTURE_DR = (state_q == CAP_DR);
  assign SHIFT_DR   = (state_q == SH_DR);
  assign UPDATE_DR  = (state_q == UPD_DR);

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl: a queue models each selected scan path as a
// delay line (capture bits then TDI) and is popped at every falling-edge TDO.
module tb_tap_ctrl;

  logic       TCK = 1'b0;
  logic       TRST, TMS, TDI, BSR_TDO;
  logic       TDO, TDO_EN, CAPTURE_DR, SHIFT_DR, UPDATE_DR, SEL_BSR, MODE;
  logic [3:0] IR_OUT, TAP_STATE;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  localparam logic [31:0] ID = 32'h1876_5001;

  tap_ctrl dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .BSR_TDO(BSR_TDO),
    .TDO(TDO), .TDO_EN(TDO_EN), .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR),
    .UPDATE_DR(UPDATE_DR), .IR_OUT(IR_OUT), .SEL_BSR(SEL_BSR), .MODE(MODE),
    .TAP_STATE(TAP_STATE)
  );

  always #5 TCK = ~TCK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle: drive before the rise, return 1 time unit after the fall.
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic observe(input string tag);
    bit e;
    e = exp_q.pop_front();
    check({tag, "_en"}, TDO_EN, 1'b1);
    check(tag, TDO, e);
  endtask

  task automatic load_ir(input logic [3:0] code);
    tick(1, 0); tick(1, 0); tick(0, 0);
    check("state_capir", TAP_STATE, 4'd10);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    tick(0, 0);
    observe("ir_tdo");
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(code[i]);
      tick(i == 3, code[i]);
      if (i < 3) observe("ir_tdo");
    end
    check("state_ex1ir", TAP_STATE, 4'd12);
    check("ex1ir_tdo_en", TDO_EN, 1'b0);
    tick(1, 0);
    check("state_updir", TAP_STATE, 4'd15);
    check("ir_out_upd", IR_OUT, code);
    tick(0, 0);
    check("state_rti_after_ir", TAP_STATE, 4'd1);
    exp_q.delete();
  endtask

  task automatic shift_dr(input int n, input logic [63:0] data, input int cap_len,
                          input logic [31:0] cap_val, input string tag);
    tick(1, 0); tick(0, 0);
    check("capture_dr", CAPTURE_DR, 1'b1);
    for (int i = 0; i < cap_len; i++) exp_q.push_back(cap_val[i]);
    tick(0, 0);
    check("shift_dr", SHIFT_DR, 1'b1);
    observe(tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(data[i]);
      tick(i == n - 1, data[i]);
      if (i < n - 1) observe(tag);
    end
    tick(1, 0);
    check("update_dr", UPDATE_DR, 1'b1);
    tick(0, 0);
    check("state_rti_after_dr", TAP_STATE, 4'd1);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] bsr_pat;
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; BSR_TDO = 1'b0;
    #2;
    check("rst_state", TAP_STATE, 4'd0);
    check("rst_ir_out", IR_OUT, 4'b0010);
    check("rst_tdo", TDO, 1'b0);
    check("rst_tdo_en", TDO_EN, 1'b0);
    check("rst_mode", MODE, 1'b0);
    check("rst_sel_bsr", SEL_BSR, 1'b0);
    @(negedge TCK); #1;
    TRST = 1'b0;

    tick(0, 0);
    check("rti_state", TAP_STATE, 4'd1);
    check("rti_ir_out", IR_OUT, 4'b0010);
    tick(0, 0);
    check("rti_hold", TAP_STATE, 4'd1);

    // IDCODE after reset: 32 ID bits LSB first, then the shifted-in zeros.
    shift_dr(36, 64'd0, 32, ID, "idcode_tdo");

    load_ir(4'b1111);
    check("bypass_sel_bsr", SEL_BSR, 1'b0);
    check("bypass_mode", MODE, 1'b0);
    shift_dr(5, 64'b11001, 1, 32'd0, "bypass_tdo");

    // Park in PauseDR, then five TMS=1 rises must land in TLR.
    tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    check("state_pausedr", TAP_STATE, 4'd6);
    tick(0, 0);
    check("pausedr_hold", TAP_STATE, 4'd6);
    check("pause_ir_kept", IR_OUT, 4'b1111);
    for (int i = 0; i < 5; i++) tick(1, 0);
    check("tms_reset_state", TAP_STATE, 4'd0);
    check("tms_reset_ir_out", IR_OUT, 4'b0010);
    tick(0, 0);

    load_ir(4'b0000);
    check("extest_mode", MODE, 1'b1);
    check("extest_sel_bsr", SEL_BSR, 1'b1);
    bsr_pat = 8'b1011_0010;
    tick(1, 0); tick(0, 0);
    BSR_TDO = bsr_pat[0];
    exp_q.push_back(bsr_pat[0]);
    tick(0, 0);
    observe("extest_tdo");
    for (int i = 1; i < 8; i++) begin
      BSR_TDO = bsr_pat[i];
      exp_q.push_back(bsr_pat[i]);
      tick(i == 7, 1'b0);
      if (i < 7) observe("extest_tdo");
    end
    tick(1, 0); tick(0, 0);
    exp_q.delete();

    load_ir(4'b0101);
    check("unknown_mode", MODE, 1'b0);
    check("unknown_sel_bsr", SEL_BSR, 1'b0);
    shift_dr(6, 64'b101101, 1, 32'd0, "unknown_bypass_tdo");

    // Asynchronous TRST in the middle of an IR shift.
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1);
    check("mid_shir_state", TAP_STATE, 4'd11);
    check("mid_shir_en", TDO_EN, 1'b1);
    #2 TRST = 1'b1;
    #1;
    check("trst_state", TAP_STATE, 4'd0);
    check("trst_tdo_en", TDO_EN, 1'b0);
    check("trst_tdo", TDO, 1'b0);
    check("trst_ir_out", IR_OUT, 4'b0010);
    @(negedge TCK); #1;
    TRST = 1'b0;
    tick(0, 0);
    check("resume_rti", TAP_STATE, 4'd1);
    shift_dr(4, 64'd0, 32, ID, "idcode_after_trst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
